// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - fetch-to-decode pipeline register with stall/bubble control
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int         XLEN      = 64,
    parameter int         CNTW      = 16,
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [2:0] SAOK      = 3'h1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            bubble,
    input  logic [2:0]      f_stat,
    input  logic [3:0]      f_icode,
    input  logic [3:0]      f_ifun,
    input  logic [3:0]      f_rA,
    input  logic [3:0]      f_rB,
    input  logic [XLEN-1:0] f_valC,
    input  logic [XLEN-1:0] f_valP,
    output logic [2:0]      D_stat,
    output logic [3:0]      D_icode,
    output logic [3:0]      D_ifun,
    output logic [3:0]      D_rA,
    output logic [3:0]      D_rB,
    output logic [XLEN-1:0] D_valC,
    output logic [XLEN-1:0] D_valP,
    output logic            D_is_bubble,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNTW-1:0] perf_stall,
    output logic [CNTW-1:0] perf_bubble,
    output logic [CNTW-1:0] perf_load,
`endif
    output logic            ctl_err
);

    // Reset and bubble share the same NOP contents.
    always_ff @(posedge clk) begin
        if (rst || (!stall && bubble)) begin
            D_stat      <= SAOK;
            D_icode     <= NOP_ICODE;
            D_ifun      <= 4'h0;
            D_rA        <= RNONE;
            D_rB        <= RNONE;
            D_valC      <= '0;
            D_valP      <= '0;
            D_is_bubble <= 1'b1;
        end else if (!stall) begin
            D_stat      <= f_stat;
            D_icode     <= f_icode;
            D_ifun      <= f_ifun;
            D_rA        <= f_rA;
            D_rB        <= f_rB;
            D_valC      <= f_valC;
            D_valP      <= f_valP;
            D_is_bubble <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ctl_err <= !rst && stall && bubble;
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_load   <= '0;
        end else if (stall) begin
            if (perf_stall != CNT_MAX)
                perf_stall <= perf_stall + CNTW'(1);
        end else if (bubble) begin
            if (perf_bubble != CNT_MAX)
                perf_bubble <= perf_bubble + CNTW'(1);
        end else begin
            if (perf_load != CNT_MAX)
                perf_load <= perf_load + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    localparam int XLEN = 64;
    localparam int CNTW = 4;
    localparam int SAT  = (1 << CNTW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, stall, bubble;
    logic [2:0]      f_stat;
    logic [3:0]      f_icode, f_ifun, f_rA, f_rB;
    logic [XLEN-1:0] f_valC, f_valP;
    logic [2:0]      D_stat;
    logic [3:0]      D_icode, D_ifun, D_rA, D_rB;
    logic [XLEN-1:0] D_valC, D_valP;
    logic            D_is_bubble, ctl_err;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNTW-1:0] perf_stall, perf_bubble, perf_load;
`endif

    pipe_stage_reg #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_is_bubble(D_is_bubble),
`ifdef PIPE_STAGE_PERF_EN
        .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_load(perf_load),
`endif
        .ctl_err(ctl_err)
    );

    typedef struct packed {
        logic [2:0]      stat;
        logic [3:0]      icode, ifun, ra, rb;
        logic [XLEN-1:0] valc, valp;
        logic            is_bubble, err;
    } outs_t;

    typedef struct {
        logic       r, s, b;
        logic [3:0] ic;
        logic [2:0] st;
        logic [3:0] e_ic;
        logic [2:0] e_st;
        logic       e_bub, e_err;
    } vec_t;

    outs_t m;
    int    n_stall, n_bub, n_load;
    int    vectors = 0;
    int    miscompares = 0;
    vec_t  tbl [15];

    function automatic outs_t nop_val();
        outs_t o;
        o = '{stat: 3'h1, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
              valc: '0, valp: '0, is_bubble: 1'b1, err: 1'b0};
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{stat: D_stat, icode: D_icode, ifun: D_ifun, ra: D_rA, rb: D_rB,
              valc: D_valC, valp: D_valP, is_bubble: D_is_bubble, err: ctl_err};
        return o;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pick one action by priority, then describe the resulting contents.
    task automatic step(input logic r, input logic s, input logic b, input logic [2:0] st,
                        input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [XLEN-1:0] vc, input logic [XLEN-1:0] vp);
        outs_t nxt;
        rst = r; stall = s; bubble = b;
        f_stat = st; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
        nxt = m;
        if (r) begin
            nxt = nop_val();
            n_stall = 0; n_bub = 0; n_load = 0;
        end else if (s) begin
            nxt.err = b;
            n_stall = (n_stall < SAT) ? n_stall + 1 : SAT;
        end else if (b) begin
            nxt = nop_val();
            n_bub = (n_bub < SAT) ? n_bub + 1 : SAT;
        end else begin
            nxt = '{stat: st, icode: ic, ifun: fn, ra: ra, rb: rb,
                    valc: vc, valp: vp, is_bubble: 1'b0, err: 1'b0};
            n_load = (n_load < SAT) ? n_load + 1 : SAT;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic check_perf(input string name);
`ifdef PIPE_STAGE_PERF_EN
        check(name, {perf_stall, perf_bubble, perf_load},
              {CNTW'(n_stall), CNTW'(n_bub), CNTW'(n_load)});
`else
        if (name.len() == 0) $display("unused");
`endif
    endtask

    initial begin
        m = nop_val();
        n_stall = 0; n_bub = 0; n_load = 0;
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        f_stat = 3'h1; f_icode = 4'h0; f_ifun = 4'h0; f_rA = 4'h0; f_rB = 4'h0;
        f_valC = '0; f_valP = '0;

        //          r     s     b     ic    st    e_ic  e_st  e_bub e_err
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'h9, 3'h1, 4'h1, 3'h1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'h9, 3'h1, 4'h1, 3'h1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h6, 3'h1, 4'h6, 3'h1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h7, 3'h1, 4'h6, 3'h1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'h7, 3'h1, 4'h6, 3'h1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'h7, 3'h1, 4'h6, 3'h1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h7, 3'h1, 4'h7, 3'h1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h5, 3'h4, 4'h5, 3'h4, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'hC, 3'h3, 4'h1, 3'h1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h2, 3'h1, 4'h2, 3'h1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h9, 3'h2, 4'h2, 3'h1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'h9, 3'h2, 4'h9, 3'h2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 4'h4, 3'h1, 4'h9, 3'h2, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 4'h4, 3'h1, 4'h1, 3'h1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'h3, 3'h1, 4'h3, 3'h1, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].st, tbl[i].ic, tbl[i].ic + 4'h1,
                 tbl[i].ic, ~tbl[i].ic, {16{tbl[i].ic}}, {8{tbl[i].ic, 4'h0}});
            check($sformatf("row%0d", i), {D_icode, D_stat, D_is_bubble, ctl_err},
                  {tbl[i].e_ic, tbl[i].e_st, tbl[i].e_bub, tbl[i].e_err});
            check($sformatf("row%0d_full", i), dut_outs(), m);
        end

        // Full-width load of every field.
        step(1'b0, 1'b0, 1'b0, 3'h1, 4'h3, 4'hA, 4'h5, 4'h2, 64'h0123_4567_89AB_CDEF, 64'h10);
        check("load_full", dut_outs(),
              {3'h1, 4'h3, 4'hA, 4'h5, 4'h2, 64'h0123_4567_89AB_CDEF, 64'h10, 1'b0, 1'b0});

        // Bubble clears ifun/valP on a register holding live data.
        step(1'b0, 1'b0, 1'b1, 3'h1, 4'h5, 4'h7, 4'h1, 4'h1, '1, '1);
        check("bubble_fields", {D_icode, D_ifun, D_valP, D_is_bubble},
              {4'h1, 4'h0, 64'h0, 1'b1});

        // Reset during a stall discards held contents.
        step(1'b0, 1'b0, 1'b0, 3'h3, 4'hE, 4'h2, 4'h3, 4'h4, 64'h55, 64'h66);
        step(1'b0, 1'b1, 1'b0, 3'h3, 4'hD, 4'h2, 4'h3, 4'h4, 64'h55, 64'h66);
        step(1'b1, 1'b1, 1'b0, 3'h3, 4'hD, 4'h2, 4'h3, 4'h4, 64'h55, 64'h66);
        check("rst_in_stall", dut_outs(), nop_val());

        // Counter saturation with a long stall.
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, 3'h1, 4'h8, 4'h0, 4'h0, 4'h0, '0, '0);
        check("stall_hold20", dut_outs(), nop_val());
        check_perf("perf_sat");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
            check("rand", dut_outs(), m);
            check_perf("rand_perf");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
